uart_rx: RTL and testbench

UART receiver for the 8N1 serial link, 115200 baud from the 30 MHz system clock. It is the receive-side counterpart of the transmit controller. It samples the incoming serial line at mid-bit, assembles bytes and presents each byte to the CPU through a one-entry valid/ready holding register. It drives flow control (pin_rts) back to the remote device and reports framing and overrun errors.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready holding register.
//
// The line is sampled at mid-bit. Timing is derived from a down-counter that
// reloads on every state entry and acts when it reaches zero.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pin_rx     serial input, idle high, asynchronous to clk
//   pin_rts    flow control to the remote device: 1 = holding register full
//   valid      holding register contains an unread byte
//   data       received byte, stable while valid=1
//   ready      consumer accepts the byte (transfer on valid & ready)
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped because the register was full
//
// state   | meaning
// S_IDLE  | line idle, waiting for a start edge
// S_START | counting to the start-bit middle, rejects glitches
// S_DATA  | sampling the 8 data bits, LSB first
// S_STOP  | counting to the stop-bit middle, then deliver / drop / flag
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 260,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin_rx,
    output logic       pin_rts,
    output logic       valid,
    output logic [7:0] data,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta, rx_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            load_d, ferr_d, ovr_d;
    logic            cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = CW'(HALF_BIT - 1);
                end
            end
            S_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                end
            end
            S_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CW'(CLKS_PER_BIT - 1);
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s) begin
                    state_d = S_IDLE;
                    // A read on this same edge frees the slot for the new byte.
                    if (!valid || ready) begin
                        load_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    state_d = S_BREAK;
                    ferr_d  = 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            pin_rts   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= pin_rx;
            rx_s      <= rx_meta;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            frame_err <= ferr_d;
            overrun   <= ovr_d;
            pin_rts   <= valid;
            if (load_d) begin
                data  <= shift_q;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. Frames are driven bit by bit on
// pin_rx; a monitor records valid rising edges, error pulses and timing.
module tb_uart_rx;

    localparam int CPB = 260;

    logic       clk;
    logic       rst_n;
    logic       pin_rx;
    logic       pin_rts;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int rises = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int both_cnt = 0;
    int last_data = 0;
    int last_rise_cyc = 0;
    int rts_at_rise = 0;
    int fall_cyc = 0;
    logic prev_valid = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_rx    (pin_rx),
        .pin_rts   (pin_rts),
        .valid     (valid),
        .data      (data),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (valid && !prev_valid) begin
            rises++;
            last_data     = int'(data);
            last_rise_cyc = cyc;
            rts_at_rise   = int'(pin_rts);
        end
        prev_valid = valid;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at the drive phase (1 time unit after an edge); returns there.
    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        pin_rx   = 1'b0;
        fall_cyc = cyc;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            pin_rx = b[i];
            cycles(CPB);
        end
        pin_rx = stop_v;
        cycles(CPB);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         gap;
        int         exp_rises;
        int         exp_data;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int r0, f0, o0, lat;

        vecs[0] = '{8'h00, 1'b1, 0,  1, 'h00, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 0,  1, 'hFF, 0, 0};
        vecs[2] = '{8'h55, 1'b1, 20, 1, 'h55, 0, 0};
        vecs[3] = '{8'h81, 1'b0, 20, 0, 0,    1, 0};
        vecs[4] = '{8'hC3, 1'b1, 20, 1, 'hC3, 0, 0};

        rst_n  = 1'b0;
        pin_rx = 1'b1;
        ready  = 1'b0;
        cycles(5);
        check("reset_valid", int'(valid), 0);
        check("reset_data", int'(data), 0);
        check("reset_rts", int'(pin_rts), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_ovr", int'(overrun), 0);
        rst_n = 1'b1;
        cycles(5);

        // Latency and handshake for a single byte with ready low.
        r0 = rises;
        send_frame(8'hA5, 1'b1);
        cycles(5);
        check("a5_rise", rises - r0, 1);
        lat = last_rise_cyc - fall_cyc;
        check("a5_latency_ok", int'(lat >= 2472 && lat <= 2474), 1);
        check("a5_data", last_data, 'hA5);
        check("a5_rts_lag", rts_at_rise, 0);
        check("a5_rts_full", int'(pin_rts), 1);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        check("a5_read_valid", int'(valid), 0);
        check("a5_read_rts_hold", int'(pin_rts), 1);
        cycles(1);
        check("a5_read_rts", int'(pin_rts), 0);

        // Table: back-to-back frames with ready held, plus a framing error.
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(vecs[i].byte_v, vecs[i].stop_v);
            pin_rx = 1'b1;
            if (vecs[i].gap > 0) cycles(vecs[i].gap);
            check($sformatf("vec%0d_rises", i), rises - r0, vecs[i].exp_rises);
            if (vecs[i].exp_rises > 0)
                check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, vecs[i].exp_ovr);
        end
        cycles(20);
        check("table_valid_clear", int'(valid), 0);

        // Short low glitch must be rejected.
        r0 = rises; f0 = ferr_cnt;
        pin_rx = 1'b0;
        cycles(100);
        pin_rx = 1'b1;
        cycles(300);
        check("glitch_rises", rises - r0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        cycles(10);
        check("post_glitch_rises", rises - r0, 1);
        check("post_glitch_data", last_data, 'h3C);

        // Long break: one framing error only.
        r0 = rises; f0 = ferr_cnt;
        send_frame(8'h81, 1'b0);
        cycles(2000);
        pin_rx = 1'b1;
        cycles(20);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_rises", rises - r0, 0);
        check("break_valid", int'(valid), 0);
        send_frame(8'h42, 1'b1);
        cycles(10);
        check("post_break_rises", rises - r0, 1);
        check("post_break_data", last_data, 'h42);

        // Overrun, then the same-edge read that avoids it.
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        cycles(10);
        check("ovr_first_data", int'(data), 'h11);
        check("ovr_first_valid", int'(valid), 1);
        o0 = ovr_cnt; f0 = ferr_cnt;
        send_frame(8'h22, 1'b1);
        cycles(10);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_data_kept", int'(data), 'h11);
        check("ovr_valid_kept", int'(valid), 1);
        check("ovr_no_ferr", ferr_cnt - f0, 0);
        o0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (2472) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        cycles(10);
        check("sameedge_no_ovr", ovr_cnt - o0, 0);
        check("sameedge_data", int'(data), 'h22);
        check("sameedge_valid", int'(valid), 1);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        cycles(5);

        // Reset in the middle of a frame.
        r0 = rises; f0 = ferr_cnt;
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (1000) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("midrst_valid", int'(valid), 0);
                check("midrst_data", int'(data), 0);
                check("midrst_rts", int'(pin_rts), 0);
                check("midrst_ferr", int'(frame_err), 0);
                check("midrst_ovr", int'(overrun), 0);
            end
        join
        cycles(5);
        rst_n = 1'b1;
        cycles(5);
        check("midrst_no_partial", rises - r0, 0);
        send_frame(8'h66, 1'b1);
        cycles(10);
        check("post_rst_rises", rises - r0, 1);
        check("post_rst_data", last_data, 'h66);
        check("post_rst_ferr", ferr_cnt - f0, 0);

        check("never_both_errors", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
